seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer.sv | 145 ++++++++++++++
 tb/tb_seq_serializer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
//
// Purpose:
//   Parallel-to-serial converter that feeds a downstream 0101 sequence
//   detector. A WIDTH-bit word is accepted from an upstream source and
//   shifted out MSB first. Each bit is held on ser_out for DIV clock cycles.
//   While idle, the line rests at 1. This keeps the detector in its reset
//   state.
//
// Parameters:
//   WIDTH  bits per word (2..32)
//   DIV    clock cycles per serial bit (1..255)
//
// Ports:
//   clock       rising-edge clock for all state
//   reset       asynchronous active-low reset
//   data_in     parallel word, sampled only on acceptance
//   load        word-valid request from upstream
//   flush       synchronous abort of the word in progress
//   ready       high when a word can be accepted
//   ser_out     serial bit stream (idle level 1)
//   bit_strobe  one-cycle pulse on the first cycle of each serial bit
//   busy        high while a word is being shifted
//   done        one-cycle pulse when a word completes normally
// ---------------------------------------------------------------------------
module seq_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             flush,
    output logic             ready,
    output logic             ser_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    // Counter widths cover DIV-1 and WIDTH-1 at the largest legal values.
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_FIRST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_d;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic [CNT_W-1:0]   bitcnt_q;
    logic [CNT_W-1:0]   bitcnt_d;
    logic               done_d;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            div_q    <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Next-state logic. A flush overrides everything, including a pending
    // load in IDLE.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;

        if (flush) begin
            state_d  = IDLE;
            shreg_d  = '0;
            div_d    = '0;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d  = SHIFT;
                        shreg_d  = data_in;
                        div_d    = '0;
                        bitcnt_d = BIT_FIRST;
                    end
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        // End of the current bit period: advance to the next bit.
                        div_d   = '0;
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        if (bitcnt_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q - CNT_W'(1);
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output registers are loaded from next-state values. As a result, they
    // show the same cycle as the state they describe. There is no path from
    // the inputs to the outputs that skips a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready      <= 1'b1;
            busy       <= 1'b0;
            ser_out    <= 1'b1;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            ready      <= (state_d == IDLE);
            busy       <= (state_d == SHIFT);
            ser_out    <= (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b1;
            bit_strobe <= (state_d == SHIFT) && (div_d == '0);
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
//
// Directed bench for seq_serializer. There are two instances:
//   dut  : WIDTH=8, DIV=4
//   dut1 : WIDTH=8, DIV=1, with ser_out feeding a small 0101 detector model
// The outputs of each instance are packed as {ready, busy, ser_out,
// bit_strobe, done}. They are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

    logic       clock;
    logic       reset;

    logic [7:0] data_in;
    logic       load;
    logic       flush;
    logic       ready;
    logic       ser_out;
    logic       bit_strobe;
    logic       busy;
    logic       done;

    logic [7:0] data_in1;
    logic       load1;
    logic       flush1;
    logic       ready1;
    logic       ser_out1;
    logic       bit_strobe1;
    logic       busy1;
    logic       done1;

    logic [4:0] vec0;
    logic [4:0] vec1;
    logic [3:0] det_hist;
    logic       det_hit;

    int passed;
    int total;

    localparam logic [4:0] V_IDLE = 5'b10100;

    seq_serializer #(.WIDTH(8), .DIV(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .flush      (flush),
        .ready      (ready),
        .ser_out    (ser_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done)
    );

    seq_serializer #(.WIDTH(8), .DIV(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in1),
        .load       (load1),
        .flush      (flush1),
        .ready      (ready1),
        .ser_out    (ser_out1),
        .bit_strobe (bit_strobe1),
        .busy       (busy1),
        .done       (done1)
    );

    assign vec0 = {ready, busy, ser_out, bit_strobe, done};
    assign vec1 = {ready1, busy1, ser_out1, bit_strobe1, done1};

    // 0101 detector on the DIV=1 stream. It sits in reset while the line idles at 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) det_hist <= 4'b1111;
        else        det_hist <= {det_hist[2:0], ser_out1};
    end
    assign det_hit = (det_hist == 4'b0101);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs c cycles after the accepting edge for an 8-bit word w.
    function automatic logic [4:0] exp_vec(input logic [7:0] w, input int c, input int div);
        int bi;
        if (c >= 1 && c <= 8 * div) begin
            bi = 7 - (c - 1) / div;
            return {1'b0, 1'b1, w[bi], ((c - 1) % div) == 0, 1'b0};
        end else if (c == 8 * div + 1) begin
            return 5'b10101;
        end
        return V_IDLE;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        load  = 1'b1;
        load1 = 1'b1;
        data_in  = 8'hC3;
        data_in1 = 8'hC3;
        tick();
        tick();
        total++;
        if (vec0 !== V_IDLE) $display("FAIL reset_dut vec=%b exp=%b", vec0, V_IDLE);
        else passed++;
        total++;
        if (vec1 !== V_IDLE) $display("FAIL reset_dut1 vec=%b exp=%b", vec1, V_IDLE);
        else passed++;
        load  = 1'b0;
        load1 = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (vec0 !== V_IDLE) $display("FAIL reset_release vec=%b exp=%b", vec0, V_IDLE);
        else passed++;
    endtask

    task automatic test_basic();
        int strobes;
        int dones;
        strobes = 0;
        dones   = 0;
        data_in = 8'h35;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            total++;
            if (vec0 !== exp_vec(8'h35, c, 4))
                $display("FAIL basic c=%0d vec=%b exp=%b", c, vec0, exp_vec(8'h35, c, 4));
            else passed++;
            if (bit_strobe) strobes++;
            if (done) dones++;
            tick();
        end
        total++;
        if (strobes !== 8) $display("FAIL basic_strobe_count got=%0d exp=8", strobes);
        else passed++;
        total++;
        if (dones !== 1) $display("FAIL basic_done_count got=%0d exp=1", dones);
        else passed++;
    endtask

    task automatic test_busy_reject();
        data_in = 8'h35;
        load    = 1'b1;
        tick();
        data_in = 8'hFF;
        for (int c = 1; c <= 33; c++) begin
            total++;
            if (vec0 !== exp_vec(8'h35, c, 4))
                $display("FAIL busy_reject c=%0d vec=%b exp=%b", c, vec0, exp_vec(8'h35, c, 4));
            else passed++;
            tick();
        end
        load = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            total++;
            if (vec0 !== exp_vec(8'hFF, c, 4))
                $display("FAIL busy_next c=%0d vec=%b exp=%b", c, vec0, exp_vec(8'hFF, c, 4));
            else passed++;
            tick();
        end
    endtask

    task automatic test_flush();
        int dones;
        dones   = 0;
        data_in = 8'hA5;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            total++;
            if (vec0 !== exp_vec(8'hA5, c, 4))
                $display("FAIL flush_pre c=%0d vec=%b exp=%b", c, vec0, exp_vec(8'hA5, c, 4));
            else passed++;
            if (c < 18) tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (vec0 !== V_IDLE) $display("FAIL flush_idle vec=%b exp=%b", vec0, V_IDLE);
        else passed++;
        for (int c = 0; c < 20; c++) begin
            if (done) dones++;
            tick();
        end
        total++;
        if (dones !== 0) $display("FAIL flush_no_done got=%0d exp=0", dones);
        else passed++;
        data_in = 8'h0F;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            total++;
            if (vec0 !== exp_vec(8'h0F, c, 4))
                $display("FAIL flush_next c=%0d vec=%b exp=%b", c, vec0, exp_vec(8'h0F, c, 4));
            else passed++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        int dones;
        dones   = 0;
        data_in = 8'h5A;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            total++;
            if (vec0 !== exp_vec(8'h5A, c, 4))
                $display("FAIL areset_pre c=%0d vec=%b exp=%b", c, vec0, exp_vec(8'h5A, c, 4));
            else passed++;
            if (c < 10) tick();
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (vec0 !== V_IDLE) $display("FAIL areset_immediate vec=%b exp=%b", vec0, V_IDLE);
        else passed++;
        #1;
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) $display("FAIL areset_quiet got=%0d exp=0", dones);
        else passed++;
    endtask

    task automatic test_back_to_back();
        data_in1 = 8'h50;
        load1    = 1'b1;
        tick();
        data_in1 = 8'h05;
        for (int c = 1; c <= 9; c++) begin
            total++;
            if (vec1 !== exp_vec(8'h50, c, 1))
                $display("FAIL b2b_first c=%0d vec=%b exp=%b", c, vec1, exp_vec(8'h50, c, 1));
            else passed++;
            tick();
        end
        load1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            total++;
            if (vec1 !== exp_vec(8'h05, c, 1))
                $display("FAIL b2b_second c=%0d vec=%b exp=%b", c, vec1, exp_vec(8'h05, c, 1));
            else passed++;
            tick();
        end
    endtask

    task automatic test_system();
        logic [9:0] det_exp;
        det_exp  = 10'b0101010000;
        data_in1 = 8'h55;
        load1    = 1'b1;
        tick();
        load1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            total++;
            if (det_hit !== det_exp[c-1])
                $display("FAIL system_detect c=%0d hit=%b exp=%b", c, det_hit, det_exp[c-1]);
            else passed++;
            tick();
        end
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        reset    = 1'b0;
        data_in  = '0;
        load     = 1'b0;
        flush    = 1'b0;
        data_in1 = '0;
        load1    = 1'b0;
        flush1   = 1'b0;

        test_reset();
        test_basic();
        test_busy_reject();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_system();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
